controle_lampada: RTL and testbench

Lamp mode controller at the actuator end of the auto-shutdown path. It consumes the one-cycle shutdown pulse `c` from the presence timer, the infrared presence input and a raw push button. It then decides whether the lamp is lit. Push-button presses are debounced and classified as short or long: long toggles automatic/manual mode, short toggles the lamp in manual mode.

---
 rtl/controle_lampada.sv | 166 ++++++++++++++++
 tb/tb_controle_lampada.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/controle_lampada.sv
// -----------------------------------------------------------------------------
// controle_lampada
//
// Lamp mode controller at the actuator end of the auto-shutdown path.
// A raw push button is debounced and each press is classified on release as
// short or long. A long press toggles between automatic and manual mode; a
// short press toggles the lamp while in manual mode. In automatic mode the
// lamp follows the infrared presence input and is switched off by the
// one-cycle shutdown pulse coming from the presence timer.
//
// Parameters
//   DEBOUNCE_T : minimum consecutive high samples for a valid press
//                (1 <= DEBOUNCE_T < LONG_T)
//   LONG_T     : high-sample count at or above which a press is long
//
// Ports
//   clk           in  : single clock, everything updates on posedge
//   rst           in  : synchronous active-high reset
//   push_button   in  : raw button level, 1 = pressed (already in clk domain)
//   infravermelho in  : presence detected, 1 = person present
//   c             in  : one-cycle auto-shutdown pulse
//   led           out : lamp drive, 1 = on
//   manual        out : 1 while in manual mode
// -----------------------------------------------------------------------------
module controle_lampada #(
    parameter int DEBOUNCE_T = 50,
    parameter int LONG_T     = 5000
) (
    input  logic clk,
    input  logic rst,
    input  logic push_button,
    input  logic infravermelho,
    input  logic c,
    output logic led,
    output logic manual
);

    // Counter is wide enough to hold LONG_T itself, where it saturates.
    localparam int CW = $clog2(LONG_T + 1);

    localparam logic [CW-1:0] LONG_C     = CW'(LONG_T);
    localparam logic [CW-1:0] DEBOUNCE_C = CW'(DEBOUNCE_T);
    localparam logic [CW-1:0] ONE_C      = CW'(1);

    typedef enum logic [1:0] {
        AUTO_OFF   = 2'b00,
        AUTO_ON    = 2'b01,
        MANUAL_OFF = 2'b10,
        MANUAL_ON  = 2'b11
    } state_t;

    // -------------------------------------------------------------------------
    // Press counter and release classification
    // -------------------------------------------------------------------------
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          long_evt_q;
    logic          long_evt_d;
    logic          short_evt_q;
    logic          short_evt_d;

    logic          cnt_at_long;
    logic          cnt_at_debounce;

    // Classification thresholds look at the count accumulated before the
    // release sample; the release sample itself never adds to it.
    assign cnt_at_long     = (cnt_q >= LONG_C);
    assign cnt_at_debounce = (cnt_q >= DEBOUNCE_C);

    always_comb begin
        cnt_d       = cnt_q;
        long_evt_d  = 1'b0;
        short_evt_d = 1'b0;

        if (push_button) begin
            // Holding the button past LONG_T just parks the counter; the
            // event is only produced once the button is let go.
            if (!cnt_at_long) begin
                cnt_d = cnt_q + ONE_C;
            end
        end else begin
            if (cnt_at_long) begin
                long_evt_d = 1'b1;
            end else if (cnt_at_debounce) begin
                short_evt_d = 1'b1;
            end
            // Anything shorter than the debounce window is a glitch and is
            // dropped silently. A single low sample is enough to re-arm.
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            long_evt_q  <= 1'b0;
            short_evt_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            long_evt_q  <= long_evt_d;
            short_evt_q <= short_evt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Mode / lamp state machine
    //
    // Priority inside one edge: long_evt > short_evt > c > infravermelho.
    // The events are registered, so the state reacts one edge after the
    // release was sampled (two cycles from release to visible output).
    // -------------------------------------------------------------------------
    state_t state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= AUTO_OFF;
        end else begin
            case (state_q)
                AUTO_OFF: begin
                    if (long_evt_q) begin
                        state_q <= MANUAL_OFF;
                    end else if (infravermelho) begin
                        state_q <= AUTO_ON;
                    end
                end

                AUTO_ON: begin
                    // c wins over presence: a shutdown pulse coinciding with
                    // presence still turns the lamp off; the next presence
                    // sample relights it from AUTO_OFF.
                    if (long_evt_q) begin
                        state_q <= MANUAL_ON;
                    end else if (c) begin
                        state_q <= AUTO_OFF;
                    end
                end

                MANUAL_OFF: begin
                    if (long_evt_q) begin
                        state_q <= AUTO_OFF;
                    end else if (short_evt_q) begin
                        state_q <= MANUAL_ON;
                    end
                end

                MANUAL_ON: begin
                    if (long_evt_q) begin
                        state_q <= AUTO_OFF;
                    end else if (short_evt_q) begin
                        state_q <= MANUAL_OFF;
                    end
                end

                default: begin
                    state_q <= AUTO_OFF;
                end
            endcase
        end
    end

    // Outputs are pure decodes of the state register, so they are glitch-free
    // and change exactly on the state transition edge.
    assign led    = (state_q == AUTO_ON)    || (state_q == MANUAL_ON);
    assign manual = (state_q == MANUAL_OFF) || (state_q == MANUAL_ON);

endmodule

// File: tb/tb_controle_lampada.sv
// -----------------------------------------------------------------------------
// Testbench for controle_lampada (DEBOUNCE_T=4, LONG_T=20).
// Stimulus pushes the expected led/manual value for each cycle into a
// scoreboard queue; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_controle_lampada;

    localparam int DEB = 4;
    localparam int LNG = 20;

    logic clk = 1'b0;
    logic rst;
    logic push_button;
    logic infravermelho;
    logic c;
    logic led;
    logic manual;

    always #5 clk = ~clk;

    controle_lampada #(
        .DEBOUNCE_T (DEB),
        .LONG_T     (LNG)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .push_button   (push_button),
        .infravermelho (infravermelho),
        .c             (c),
        .led           (led),
        .manual        (manual)
    );

    typedef struct {
        string name;
        logic  led;
        logic  man;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_checks   = 0;
    int n_fail     = 0;
    int long_seen  = 0;
    int short_seen = 0;
    int base_long;
    int base_short;

    // Monitor: count event pulses and compare outputs against the scoreboard.
    always @(negedge clk) begin
        if (dut.long_evt_q === 1'b1)  long_seen  = long_seen + 1;
        if (dut.short_evt_q === 1'b1) short_seen = short_seen + 1;
        if (sb.size() > 0) begin
            mon_e    = sb.pop_front();
            n_checks = n_checks + 1;
            if (led !== mon_e.led || manual !== mon_e.man) begin
                n_fail = n_fail + 1;
                $display("FAIL %s: led=%b manual=%b, required led=%b manual=%b",
                         mon_e.name, led, manual, mon_e.led, mon_e.man);
            end else begin
                $display("ok   %s: led=%b manual=%b", mon_e.name, led, manual);
            end
        end
    end

    // One cycle of stimulus plus the outputs required after the next edge.
    task automatic step(input logic r, input logic p, input logic ir,
                        input logic cc, input logic el, input logic em,
                        input string nm);
        exp_t e;
        @(negedge clk);
        #1;
        rst           = r;
        push_button   = p;
        infravermelho = ir;
        c             = cc;
        e.name = nm;
        e.led  = el;
        e.man  = em;
        sb.push_back(e);
    endtask

    // Press for n cycles, then release; outputs change on the second edge
    // after the first low sample.
    task automatic press(input int n, input logic el0, input logic em0,
                         input logic el1, input logic em1, input string nm);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, el0, em0, nm);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, el0, em0, {nm, "_release"});
        step(1'b0, 1'b0, 1'b0, 1'b0, el1, em1, {nm, "_after"});
    endtask

    task automatic check(input string nm, input int act, input int req);
        n_checks = n_checks + 1;
        if (act != req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end else begin
            $display("ok   %s: %0d", nm, act);
        end
    endtask

    initial begin
        rst           = 1'b1;
        push_button   = 1'b1;
        infravermelho = 1'b1;
        c             = 1'b1;

        // Reset with every input active: outputs must stay low.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "reset_hold");
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "reset_release_ir");

        // Automatic mode: presence lights, shutdown pulse darkens.
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "auto_c_off");
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "auto_ir_on");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "auto_on_idle");
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "auto_c_and_ir");
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "auto_relight");
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "auto_c_again");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "auto_off_idle");

        // Glitch and short press in automatic mode change nothing.
        press(3, 1'b0, 1'b0, 1'b0, 1'b0, "auto_glitch3");
        press(4, 1'b0, 1'b0, 1'b0, 1'b0, "auto_short4");

        // Long press from AUTO_ON goes to MANUAL_ON, shorts toggle the lamp.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "auto_ir_on2");
        press(25, 1'b1, 1'b0, 1'b1, 1'b1, "long25_to_manual");
        press(6,  1'b1, 1'b1, 1'b0, 1'b1, "short6_off");
        press(6,  1'b0, 1'b1, 1'b1, 1'b1, "short6_on");

        // Debounce boundary in manual mode.
        press(3, 1'b1, 1'b1, 1'b1, 1'b1, "man_glitch3");
        press(4, 1'b1, 1'b1, 1'b0, 1'b1, "man_short4_off");
        press(4, 1'b0, 1'b1, 1'b1, 1'b1, "man_short4_on");

        // Manual mode ignores presence and shutdown.
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "man_on_c");
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "man_on_ir");
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, "man_on_c_ir");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "man_on_idle");

        // Exactly LONG_T is long; LONG_T-1 is short.
        press(20, 1'b1, 1'b1, 1'b0, 1'b0, "long20_to_auto");
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "auto_ir_on3");
        press(25, 1'b1, 1'b0, 1'b1, 1'b1, "long25_to_manual2");
        press(19, 1'b1, 1'b1, 1'b0, 1'b1, "short19_off");
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "man_off_ir");
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "man_off_c");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "man_off_idle");

        // 50-cycle hold: saturation, no event while held, one on release.
        base_long = long_seen;
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "hold50");
        end
        @(posedge clk);
        #1;
        check("hold50_cnt_saturated", int'(dut.cnt_q), LNG);
        check("hold50_no_event_while_held", long_seen, base_long);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "hold50_release");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "hold50_after");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "hold50_idle");
        check("hold50_one_long_evt", long_seen, base_long + 1);

        // Reset in the middle of a press: pre-reset high time is lost.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "auto_ir_on4");
        press(25, 1'b1, 1'b0, 1'b1, 1'b1, "long25_to_manual3");
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "pre_reset_press");
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "reset_mid_press");
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "post_reset_press");
        end
        base_long  = long_seen;
        base_short = short_seen;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "post_reset_release");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "post_reset_after");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "post_reset_idle");
        check("post_reset_short_evt", short_seen, base_short + 1);
        check("post_reset_no_long_evt", long_seen, base_long);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 5; i++) begin
            if (sb.size() != 0) @(negedge clk);
        end
        #1;
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
